led_flash_sequencer: RTL

//   Output-side counterpart of the button edge path: turns single-cycle event pulses into visible LED flashes.

---
 rtl/led_flash_pkg.sv | 11 +
 rtl/flash_timer.sv | 30 +++
 rtl/led_flash_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/led_flash_pkg.sv
// Shared types for the LED flash sequencer: the FSM state encoding used by
// the sequencer and visible on its debug state output.
package led_flash_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } flash_state_t;

endpackage

// File: rtl/flash_timer.sv
// Phase timer shared by the ON and GAP phases: counts up from 0 after clear and
// raises done on the last count of a phase that is load_len cycles long.
module flash_timer #(
    parameter int TW = 1,
    parameter int LW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [LW-1:0] load_len,
    output logic          done
);

    logic [TW-1:0] count;
    logic [LW-1:0] last;

    assign last = load_len - LW'(1);
    assign done = (LW'(count) == last);

    // Holds at the last count instead of wrapping; the FSM always leaves
    // the phase on done, which clears the counter.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (!done) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/led_flash_sequencer.sv
// Turns single-cycle event strobes into LED flashes (ON_CYCLES lit, GAP_CYCLES
// dark), queueing events that arrive mid-flash in a saturating pending counter.
module led_flash_sequencer
    import led_flash_pkg::*;
#(
    parameter int ON_CYCLES   = 25_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int MAX_PENDING = 7,
    localparam int PW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          dropped,
    output logic [1:0]    fsm_state
);

    localparam int MAX_LEN = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    generate
        if (ON_CYCLES < 1 || GAP_CYCLES < 1 || MAX_PENDING < 1) begin : g_bad_params
            $error("led_flash_sequencer: ON_CYCLES, GAP_CYCLES and MAX_PENDING must be >= 1");
        end
    endgenerate

    flash_state_t  state, state_next;
    logic [PW-1:0] pending_next;
    logic          drop_next;
    logic [LW-1:0] load_len;
    logic          timer_clear;
    logic          done;

    assign fsm_state   = state;
    assign load_len    = (state == S_ON) ? LW'(ON_CYCLES) : LW'(GAP_CYCLES);
    assign timer_clear = (state_next != state) || (state == S_IDLE);

    flash_timer #(
        .TW (TW),
        .LW (LW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .load_len (load_len),
        .done     (done)
    );

    always_comb begin
        state_next   = state;
        pending_next = pending;
        drop_next    = 1'b0;
        case (state)
            S_IDLE: begin
                if (in) state_next = S_ON;
            end
            S_ON: begin
                if (in) begin
                    if (pending == PEND_MAX) drop_next = 1'b1;
                    else                     pending_next = pending + PW'(1);
                end
                if (done) state_next = S_GAP;
            end
            S_GAP: begin
                if (done) begin
                    // A queued event starts straight away; a new strobe on the
                    // same cycle replaces the one leaving the queue.
                    if (pending != '0) begin
                        state_next = S_ON;
                        if (!in) pending_next = pending - PW'(1);
                    end else if (in) begin
                        state_next = S_ON;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (in) begin
                    if (pending == PEND_MAX) drop_next = 1'b1;
                    else                     pending_next = pending + PW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            out     <= (state_next == S_ON);
            busy    <= (state_next != S_IDLE);
            dropped <= drop_next;
        end
    end

endmodule
